// File: rtl/uart_rx_oversampled.sv
// UART receiver: 2-flop rx synchroniser, start-bit validation at half a bit,
// centre sampling of data/parity/stop bits, registered byte output with error flags.
module uart_rx_oversampled #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   pbit_q, pbit_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   par_xor;

  // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments only; the comb block below uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      pbit_q       <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      pbit_q       <= pbit_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign par_xor = ^shift_q ^ pbit_q;

  // NOTE: every variable gets its hold/default value first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    pbit_d       = pbit_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;

    if (tick_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_d = '0;
              state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            pbit_d  = rx_s_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s_q;
            rx_valid_d  = 1'b1;
            // Odd parity expects the XOR of data and parity bit to be 1, even expects 0.
            if (PARITY == 1)      parity_err_d = ~par_xor;
            else if (PARITY == 2) parity_err_d = par_xor;
            else                  parity_err_d = 1'b0;
            state_d = rx_s_q ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: an 8N1 instance and an 8E1 instance,
// directed frames push expected bytes, per-instance monitors pop on rx_valid.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       rx0, rx2;
  logic [7:0] data0, data2;
  logic       valid0, valid2, perr0, perr2, ferr0, ferr2, busy0, busy2;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .parity_err(perr0),
    .frame_err(ferr0), .busy(busy0)
  );

  uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .rx(rx2),
    .rx_data(data2), .rx_valid(valid2), .parity_err(perr2),
    .frame_err(ferr2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    return e;
  endfunction

  initial begin
    tick_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid0) begin
        if (q0.size() == 0) check("dut0_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("dut0_rx_data", {24'd0, data0}, {24'd0, e.data});
          check("dut0_parity_err", {31'd0, perr0}, {31'd0, e.perr});
          check("dut0_frame_err", {31'd0, ferr0}, {31'd0, e.ferr});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid2) begin
        if (q2.size() == 0) check("dut2_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          check("dut2_rx_data", {24'd0, data2}, {24'd0, e.data});
          check("dut2_parity_err", {31'd0, perr2}, {31'd0, e.perr});
          check("dut2_frame_err", {31'd0, ferr2}, {31'd0, e.ferr});
        end
      end
    end
  end

  task automatic send_bit(input int sel, input logic b);
    if (sel == 0) rx0 = b;
    else          rx2 = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (has_par) send_bit(sel, pbit);
    send_bit(sel, stop);
  endtask

  task automatic idle(input int bits);
    rx0 = 1'b1;
    rx2 = 1'b1;
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    rx0 = 1'b1;
    rx2 = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy0", {31'd0, busy0}, 32'd0);
    check("reset_valid0", {31'd0, valid0}, 32'd0);
    check("reset_data0", {24'd0, data0}, 32'd0);
    check("reset_perr0", {31'd0, perr0}, 32'd0);
    check("reset_ferr0", {31'd0, ferr0}, 32'd0);
    check("reset_busy2", {31'd0, busy2}, 32'd0);
    check("reset_data2", {24'd0, data2}, 32'd0);
    idle(2);

    // Plain 8N1 frame, then output must hold while the line idles.
    q0.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("hold_data0", {24'd0, data0}, 32'h0000_00A5);
    check("idle_busy0", {31'd0, busy0}, 32'd0);

    // False start: 4 ticks low, rejected at the half-bit check.
    rx0 = 1'b0;
    repeat (16) @(negedge clk);
    check("false_start_busy_high", {31'd0, busy0}, 32'd1);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    check("false_start_busy_low", {31'd0, busy0}, 32'd0);
    idle(2);

    // Stop bit low and line held low: a single framing-error frame.
    q0.push_back(mk(8'h55, 1'b0, 1'b1));
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    check("break_busy", {31'd0, busy0}, 32'd1);
    idle(2);
    check("after_break_busy", {31'd0, busy0}, 32'd0);
    q0.push_back(mk(8'h0F, 1'b0, 1'b0));
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Even parity on 0x03 (XOR of data = 0): parity bit 1 is wrong, 0 is right.
    q2.push_back(mk(8'h03, 1'b1, 1'b0));
    send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1);
    idle(2);
    q2.push_back(mk(8'h03, 1'b0, 1'b0));
    send_frame(2, 8'h03, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of data bit 3 of 0xFF.
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    rx0 = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_rst_busy", {31'd0, busy0}, 32'd0);
    check("midframe_rst_valid", {31'd0, valid0}, 32'd0);
    check("midframe_rst_data", {24'd0, data0}, 32'd0);
    idle(2);
    q0.push_back(mk(8'h3C, 1'b0, 1'b0));
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Back-to-back frames with no idle gap.
    q0.push_back(mk(8'h00, 1'b0, 1'b0));
    q0.push_back(mk(8'hFF, 1'b0, 1'b0));
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    idle(2);

    check("dut0_frames_outstanding", q0.size(), 32'd0);
    check("dut2_frames_outstanding", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
